// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent tick counters sharing one programmable
// prescaler. Each channel counts prescaled ticks up to a latched terminal
// value N, in one-shot or auto-reload mode. On each expiry it produces a
// done pulse, sets a sticky expired flag and feeds a masked, registered irq.
module multi_timer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PRE_W-1:0]        prescale,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       ch_periodic,
    input  logic [NUM_CH*CNT_W-1:0] ch_load,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_stop,
    input  logic [NUM_CH-1:0]       ch_irq_en,
    input  logic [NUM_CH-1:0]       ch_clear,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_done,
    output logic [NUM_CH-1:0]       ch_expired,
    output logic [NUM_CH*CNT_W-1:0] ch_count,
    output logic                    irq
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} ch_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    logic             any_busy;
    logic             tick;
    logic             irq_q;
    logic             irq_d;

    assign any_busy = |ch_busy;
    // ">=" rather than "==" so a prescale reduced below the running count
    // ticks immediately instead of wrapping through the full counter range.
    assign tick     = any_busy && (pre_cnt_q >= prescale);

    // Prescaler next state: parked at 0 while idle so a fresh start gets a full first period.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_ONE;
        if (!any_busy || tick) begin
            pre_cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ch_state_e        state_q;
        ch_state_e        state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] n_q;
        logic [CNT_W-1:0] n_d;
        logic             periodic_q;
        logic             periodic_d;
        logic             done_q;
        logic             done_d;
        logic             expired_q;
        logic             expired_d;
        logic [CNT_W-1:0] load_i;

        assign load_i = ch_load[gi*CNT_W +: CNT_W];

        // Channel next state: abort beats start, start beats a tick, so a
        // restart that lands on the terminal tick never produces a done.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            n_d        = n_q;
            periodic_d = periodic_q;
            done_d     = 1'b0;
            if (ch_stop[gi] || !ch_enable[gi]) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (ch_start[gi] && (load_i != '0)) begin
                state_d    = ST_RUN;
                cnt_d      = '0;
                n_d        = load_i;
                periodic_d = ch_periodic[gi];
            end else if ((state_q == ST_RUN) && tick) begin
                if (cnt_q == (n_q - CNT_ONE)) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (!periodic_q) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // An expiry in the same cycle as a clear leaves the flag set.
            expired_d = done_d ? 1'b1 : (ch_clear[gi] ? 1'b0 : expired_q);
        end

        // Channel registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                n_q        <= '0;
                periodic_q <= 1'b0;
                done_q     <= 1'b0;
                expired_q  <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                n_q        <= n_d;
                periodic_q <= periodic_d;
                done_q     <= done_d;
                expired_q  <= expired_d;
            end
        end

        assign ch_busy[gi]                  = (state_q == ST_RUN);
        assign ch_done[gi]                  = done_q;
        assign ch_expired[gi]               = expired_q;
        assign ch_count[gi*CNT_W +: CNT_W]  = cnt_q;
    end

    assign irq_d = |(ch_expired & ch_irq_en);

    // Interrupt register: one cycle behind the expired flags it summarises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_multi_timer.sv
// Directed testbench for multi_timer (NUM_CH=4, CNT_W=32, PRE_W=16).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_multi_timer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  prescale;
    logic [3:0]   ch_enable;
    logic [3:0]   ch_periodic;
    logic [127:0] ch_load;
    logic [3:0]   ch_start;
    logic [3:0]   ch_stop;
    logic [3:0]   ch_irq_en;
    logic [3:0]   ch_clear;
    logic [3:0]   ch_busy;
    logic [3:0]   ch_done;
    logic [3:0]   ch_expired;
    logic [127:0] ch_count;
    logic         irq;

    int tests_run    = 0;
    int tests_failed = 0;

    multi_timer #(.NUM_CH(4), .CNT_W(32), .PRE_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prescale    (prescale),
        .ch_enable   (ch_enable),
        .ch_periodic (ch_periodic),
        .ch_load     (ch_load),
        .ch_start    (ch_start),
        .ch_stop     (ch_stop),
        .ch_irq_en   (ch_irq_en),
        .ch_clear    (ch_clear),
        .ch_busy     (ch_busy),
        .ch_done     (ch_done),
        .ch_expired  (ch_expired),
        .ch_count    (ch_count),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land 1 ns after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b1;
        prescale    = '0;
        ch_enable   = '0;
        ch_periodic = '0;
        ch_load     = '0;
        ch_start    = '0;
        ch_stop     = '0;
        ch_irq_en   = '0;
        ch_clear    = '0;
        #2 rst_n = 1'b0;
        cyc(2);
        tests_run++;
        if ({ch_busy, ch_done, ch_expired, irq} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=0", {ch_busy, ch_done, ch_expired, irq});
        end
        tests_run++;
        if (ch_count !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_count got=%h exp=0", ch_count);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        ch_enable = 4'hF;
        ch_irq_en = 4'b0001;
        cyc(1);
        $display("[TB] test_reset done");
    endtask

    task automatic test_oneshot;
        prescale          = 16'd0;
        ch_periodic[0]    = 1'b0;
        ch_load[31:0]     = 32'd5;
        ch_start[0]       = 1'b1;
        cyc(1);                                   // edge E
        ch_start[0]       = 1'b0;
        tests_run++;
        if (ch_busy !== 4'b0001) begin
            tests_failed++;
            $display("FAIL oneshot_busy_rise got=%b exp=0001", ch_busy);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            tests_run++;
            if (ch_busy !== 4'b0001 || ch_done !== 4'b0000 || ch_count[31:0] !== 32'(k)) begin
                tests_failed++;
                $display("FAIL oneshot_run E+%0d busy=%b done=%b cnt=%0d exp busy=0001 done=0000 cnt=%0d",
                         k, ch_busy, ch_done, ch_count[31:0], k);
            end
        end
        cyc(1);                                   // E+5
        tests_run++;
        if (ch_done !== 4'b0001 || ch_busy !== 4'b0000 || ch_expired !== 4'b0001 || irq !== 1'b0
            || ch_count[31:0] !== 32'd0) begin
            tests_failed++;
            $display("FAIL oneshot_expiry done=%b busy=%b exp=%b irq=%b cnt=%0d required 0001 0000 0001 0 0",
                     ch_done, ch_busy, ch_expired, irq, ch_count[31:0]);
        end
        cyc(1);                                   // E+6
        tests_run++;
        if (ch_done !== 4'b0000 || irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL oneshot_irq done=%b irq=%b required 0000 1", ch_done, irq);
        end
        ch_clear[0] = 1'b1;
        cyc(1);
        ch_clear[0] = 1'b0;
        tests_run++;
        if (ch_expired !== 4'b0000 || irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL oneshot_clear expired=%b irq=%b required 0000 1", ch_expired, irq);
        end
        cyc(1);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL oneshot_irq_fall got=%b exp=0", irq);
        end
        $display("[TB] test_oneshot done");
    endtask

    task automatic test_periodic;
        logic [3:0]  exp_done;
        logic [31:0] exp_cnt;
        int          bad;
        prescale       = 16'd3;
        ch_periodic[1] = 1'b1;
        ch_load[63:32] = 32'd2;
        ch_start[1]    = 1'b1;
        cyc(1);                                   // edge E
        ch_start[1]    = 1'b0;
        for (int p = 1; p <= 10; p++) begin
            bad = 0;
            for (int off = 1; off <= 8; off++) begin
                cyc(1);
                exp_done = (off == 8) ? 4'b0010 : 4'b0000;
                exp_cnt  = (off >= 4 && off < 8) ? 32'd1 : 32'd0;
                if (ch_done !== exp_done || ch_count[63:32] !== exp_cnt || ch_busy !== 4'b0010) begin
                    bad++;
                    $display("FAIL periodic p%0d off%0d done=%b cnt=%0d busy=%b required %b %0d 0010",
                             p, off, ch_done, ch_count[63:32], ch_busy, exp_done, exp_cnt);
                end
            end
            tests_run++;
            if (bad != 0) tests_failed++;
        end
        ch_stop[1] = 1'b1;
        cyc(1);
        ch_stop[1] = 1'b0;
        tests_run++;
        if (ch_busy !== 4'b0000 || ch_count[63:32] !== 32'd0 || ch_expired !== 4'b0010) begin
            tests_failed++;
            $display("FAIL periodic_stop busy=%b cnt=%0d expired=%b required 0000 0 0010",
                     ch_busy, ch_count[63:32], ch_expired);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (ch_done !== 4'b0000) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL periodic_after_stop done pulses=%0d required 0", bad);
        end
        ch_periodic[1] = 1'b0;
        ch_clear       = 4'hF;
        cyc(1);
        ch_clear       = 4'h0;
        cyc(1);
        $display("[TB] test_periodic done");
    endtask

    task automatic test_simultaneous;
        prescale      = 16'd0;
        // start and stop together: stop wins
        ch_load[31:0] = 32'd5;
        ch_start[0]   = 1'b1;
        ch_stop[0]    = 1'b1;
        cyc(1);
        ch_start[0]   = 1'b0;
        ch_stop[0]    = 1'b0;
        tests_run++;
        if (ch_busy !== 4'b0000) begin
            tests_failed++;
            $display("FAIL sim_start_stop busy=%b exp=0000", ch_busy);
        end
        cyc(2);
        // restart when cnt == N-1 on a tick
        ch_load[31:0] = 32'd3;
        ch_start[0]   = 1'b1;
        cyc(1);                                   // E
        ch_start[0]   = 1'b0;
        cyc(2);                                   // E+2, cnt=2
        tests_run++;
        if (ch_count[31:0] !== 32'd2) begin
            tests_failed++;
            $display("FAIL sim_pre_restart cnt=%0d exp=2", ch_count[31:0]);
        end
        ch_start[0] = 1'b1;
        cyc(1);                                   // E+3 restart
        ch_start[0] = 1'b0;
        tests_run++;
        if (ch_done !== 4'b0000 || ch_count[31:0] !== 32'd0 || ch_busy !== 4'b0001 || ch_expired !== 4'b0000) begin
            tests_failed++;
            $display("FAIL sim_restart done=%b cnt=%0d busy=%b expired=%b required 0000 0 0001 0000",
                     ch_done, ch_count[31:0], ch_busy, ch_expired);
        end
        cyc(2);
        tests_run++;
        if (ch_done !== 4'b0000 || ch_count[31:0] !== 32'd2) begin
            tests_failed++;
            $display("FAIL sim_restart_run done=%b cnt=%0d required 0000 2", ch_done, ch_count[31:0]);
        end
        cyc(1);
        tests_run++;
        if (ch_done !== 4'b0001) begin
            tests_failed++;
            $display("FAIL sim_restart_expiry done=%b exp=0001", ch_done);
        end
        // clear first, then clear coinciding with expiry
        ch_clear[0] = 1'b1;
        cyc(1);
        ch_clear[0] = 1'b0;
        tests_run++;
        if (ch_expired !== 4'b0000) begin
            tests_failed++;
            $display("FAIL sim_clear expired=%b exp=0000", ch_expired);
        end
        ch_load[31:0] = 32'd2;
        ch_start[0]   = 1'b1;
        cyc(1);                                   // E
        ch_start[0]   = 1'b0;
        cyc(1);                                   // E+1
        ch_clear[0]   = 1'b1;
        cyc(1);                                   // E+2 expiry and clear together
        ch_clear[0]   = 1'b0;
        tests_run++;
        if (ch_done !== 4'b0001 || ch_expired !== 4'b0001) begin
            tests_failed++;
            $display("FAIL sim_clear_vs_expiry done=%b expired=%b required 0001 0001", ch_done, ch_expired);
        end
        cyc(2);
        $display("[TB] test_simultaneous done");
    endtask

    task automatic test_boundary;
        int bad;
        prescale      = 16'd0;
        // N = 0 is ignored
        ch_load[31:0] = 32'd0;
        ch_start[0]   = 1'b1;
        cyc(1);
        ch_start[0]   = 1'b0;
        tests_run++;
        if (ch_busy !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bnd_n0_busy busy=%b exp=0000", ch_busy);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (ch_done !== 4'b0000) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bnd_n0_done pulses=%0d exp=0", bad);
        end
        // N = 1, prescale 0, periodic: done every cycle
        ch_load[31:0]  = 32'd1;
        ch_periodic[0] = 1'b1;
        ch_start[0]    = 1'b1;
        cyc(1);
        ch_start[0]    = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            tests_run++;
            if (ch_done !== 4'b0001 || ch_count[31:0] !== 32'd0 || ch_busy !== 4'b0001) begin
                tests_failed++;
                $display("FAIL bnd_n1 E+%0d done=%b cnt=%0d busy=%b required 0001 0 0001",
                         k, ch_done, ch_count[31:0], ch_busy);
            end
        end
        ch_stop[0] = 1'b1;
        cyc(1);
        ch_stop[0] = 1'b0;
        tests_run++;
        if (ch_done !== 4'b0000 || ch_busy !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bnd_n1_stop done=%b busy=%b required 0000 0000", ch_done, ch_busy);
        end
        ch_periodic[0] = 1'b0;
        cyc(2);
        // prescale lowered from 100 to 2 while pre_cnt is 50
        prescale      = 16'd100;
        ch_load[31:0] = 32'd3;
        ch_start[0]   = 1'b1;
        cyc(1);                                   // E
        ch_start[0]   = 1'b0;
        cyc(50);                                  // E+50
        tests_run++;
        if (ch_count[31:0] !== 32'd0) begin
            tests_failed++;
            $display("FAIL bnd_pre_hold cnt=%0d exp=0", ch_count[31:0]);
        end
        prescale = 16'd2;
        cyc(1);                                   // E+51
        tests_run++;
        if (ch_count[31:0] !== 32'd1) begin
            tests_failed++;
            $display("FAIL bnd_pre_drop cnt=%0d exp=1", ch_count[31:0]);
        end
        cyc(2);                                   // E+53
        tests_run++;
        if (ch_count[31:0] !== 32'd1) begin
            tests_failed++;
            $display("FAIL bnd_pre_gap cnt=%0d exp=1", ch_count[31:0]);
        end
        cyc(1);                                   // E+54
        tests_run++;
        if (ch_count[31:0] !== 32'd2) begin
            tests_failed++;
            $display("FAIL bnd_pre_second cnt=%0d exp=2", ch_count[31:0]);
        end
        cyc(3);                                   // E+57
        tests_run++;
        if (ch_done !== 4'b0001 || ch_busy !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bnd_pre_expiry done=%b busy=%b required 0001 0000", ch_done, ch_busy);
        end
        cyc(2);
        $display("[TB] test_boundary done");
    endtask

    task automatic test_enable_abort;
        int bad;
        ch_clear = 4'hF;
        cyc(1);
        ch_clear = 4'h0;
        cyc(2);
        prescale        = 16'd1;
        ch_load[95:64]  = 32'd10;
        ch_load[127:96] = 32'd4;
        ch_start[3:2]   = 2'b11;
        cyc(1);                                   // E
        ch_start[3:2]   = 2'b00;
        cyc(3);                                   // E+3
        ch_enable[2]    = 1'b0;
        cyc(1);                                   // E+4
        tests_run++;
        if (ch_busy !== 4'b1000 || ch_count[95:64] !== 32'd0 || ch_count[127:96] !== 32'd2) begin
            tests_failed++;
            $display("FAIL en_abort busy=%b cnt2=%0d cnt3=%0d required 1000 0 2",
                     ch_busy, ch_count[95:64], ch_count[127:96]);
        end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            if (ch_done !== 4'b0000) bad++;
        end
        tests_run++;
        if (bad != 0 || ch_count[127:96] !== 32'd3) begin
            tests_failed++;
            $display("FAIL en_ch3_run early_done=%0d cnt3=%0d required 0 3", bad, ch_count[127:96]);
        end
        cyc(1);                                   // E+8
        tests_run++;
        if (ch_done !== 4'b1000 || ch_busy !== 4'b0000) begin
            tests_failed++;
            $display("FAIL en_ch3_expiry done=%b busy=%b required 1000 0000", ch_done, ch_busy);
        end
        cyc(1);                                   // E+9
        tests_run++;
        if (ch_expired !== 4'b1000 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_masked expired=%b irq=%b required 1000 0", ch_expired, irq);
        end
        ch_enable[2] = 1'b1;
        cyc(2);
        $display("[TB] test_enable_abort done");
    endtask

    task automatic test_async_reset;
        int bad;
        prescale      = 16'd0;
        ch_load[31:0] = 32'd4;
        ch_start[0]   = 1'b1;
        cyc(1);                                   // E
        ch_start[0]   = 1'b0;
        cyc(2);                                   // E+2
        tests_run++;
        if (ch_busy !== 4'b0001 || ch_count[31:0] !== 32'd2) begin
            tests_failed++;
            $display("FAIL arst_pre busy=%b cnt=%0d required 0001 2", ch_busy, ch_count[31:0]);
        end
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ch_busy, ch_done, ch_expired, irq} !== 13'h0 || ch_count !== 128'h0) begin
            tests_failed++;
            $display("FAIL arst_clear flags=%b count=%h required 0 0",
                     {ch_busy, ch_done, ch_expired, irq}, ch_count);
        end
        #2 rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            if (ch_done !== 4'b0000 || ch_busy !== 4'b0000) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL arst_after bad_cycles=%0d exp=0", bad);
        end
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_simultaneous();
        test_boundary();
        test_enable_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
